// File: rtl/mux_sel_sequencer_if.sv
// Parallel-load and serial-beat handshake bundle for mux_sel_sequencer.
// slave = sequencer side, master = producer/consumer side.
interface mux_sel_sequencer_if #(
  parameter int N = 2
);
  localparam int W = 2**N;

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] mux_in;
  logic [N-1:0] mux_sel;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output mux_in,
    output mux_sel,
    output out_valid,
    output out_last
  );

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  mux_in,
    input  mux_sel,
    input  out_valid,
    input  out_last
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Holds a parallel word on a mux and walks its select one index per
// accepted beat, turning the mux output into a serial bitstream.
module mux_sel_sequencer #(
  parameter int N         = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic                 busy,
  mux_sel_sequencer_if.slave   bus
);
  localparam int W = 2**N;
  localparam logic [N-1:0] ONE   = N'(1);
  localparam logic [N-1:0] TOP   = N'(W - 1);
  localparam logic [N-1:0] FIRST = MSB_FIRST ? TOP : '0;
  localparam logic [N-1:0] LASTI = MSB_FIRST ? '0 : TOP;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [N-1:0] sel_q, sel_d;
  logic         xfer;
  logic         last;
  logic         accept;

  assign bus.mux_in    = data_q;
  assign bus.mux_sel   = sel_q;
  assign bus.out_valid = (state_q == SHIFT);
  assign busy          = (state_q == SHIFT);

  assign last         = (state_q == SHIFT) && (sel_q == LASTI);
  assign bus.out_last = last;
  assign xfer         = bus.out_valid & bus.out_ready;

  // The last transfer frees the holding register, so a new word can
  // load in the same cycle without an idle bubble.
  assign bus.in_ready = !flush &&
                        ((state_q == IDLE) || (xfer && last));
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      data_d  = bus.in_data;
      sel_d   = FIRST;
      state_d = SHIFT;
    end else if (xfer && last) begin
      state_d = IDLE;
    end else if (xfer) begin
      sel_d = MSB_FIRST ? sel_q - ONE : sel_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: LSB-first and MSB-first instances,
// directed vector table, corner sequences and a randomized model check.
module tb_mux_sel_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fl0 = 1'b0, fl1 = 1'b0;
  logic busy0, busy1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.N(2)) b0 ();
  mux_sel_sequencer_if #(.N(2)) b1 ();

  mux_sel_sequencer #(.N(2), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0), .busy(busy0), .bus(b0.slave)
  );
  mux_sel_sequencer #(.N(2), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1), .busy(busy1), .bus(b1.slave)
  );

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       rdy;
    logic       fl;
    logic       ir;
    logic       ov;
    logic [1:0] sel;
    logic       mbit;
    logic       last;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic iv, logic [3:0] d, logic rdy, logic fl,
                             logic ir, logic ov, logic [1:0] sel,
                             logic mbit, logic last);
    vec_t t;
    t.iv = iv; t.d = d; t.rdy = rdy; t.fl = fl;
    t.ir = ir; t.ov = ov; t.sel = sel; t.mbit = mbit; t.last = last;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive0(logic iv, logic [3:0] d, logic rdy, logic fl);
    b0.in_valid = iv; b0.in_data = d; b0.out_ready = rdy; fl0 = fl;
  endtask

  task automatic drive1(logic iv, logic [3:0] d, logic rdy, logic fl);
    b1.in_valid = iv; b1.in_data = d; b1.out_ready = rdy; fl1 = fl;
  endtask

  logic       r_iv[2], r_rdy[2], r_fl[2];
  logic [3:0] r_d[2];
  logic       a_ir[2], a_ov[2], a_bz[2], a_last[2];
  logic [1:0] a_sel[2];
  logic [3:0] a_mi[2];
  int         q[2][$];
  logic [3:0] mword[2];
  logic [1:0] held[2];
  logic       e_ov, e_ir, e_last;
  logic [1:0] e_sel;

  initial begin
    drive0(1'b0, 4'h0, 1'b0, 1'b0);
    drive1(1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    chk("rst.ov0", int'(b0.out_valid), 0);
    chk("rst.busy0", int'(busy0), 0);
    chk("rst.sel0", int'(b0.mux_sel), 0);
    chk("rst.min0", int'(b0.mux_in), 0);
    chk("rst.ov1", int'(b1.out_valid), 0);
    chk("rst.sel1", int'(b1.mux_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LSB-first walk, back-to-back load, stall and flush
    tv.push_back(v(1, 4'b1010, 1, 0, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 2, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 1, 3, 1, 1));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 0, 3, 1, 0));
    tv.push_back(v(1, 4'b1010, 1, 0, 1, 0, 3, 1, 0));
    tv.push_back(v(1, 4'b0110, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(1, 4'b0110, 1, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(1, 4'b0110, 1, 0, 0, 1, 2, 0, 0));
    tv.push_back(v(1, 4'b0110, 1, 0, 1, 1, 3, 1, 1));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 2, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 1, 3, 0, 1));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 0, 3, 0, 0));
    tv.push_back(v(1, 4'b1010, 1, 0, 1, 0, 3, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 2, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 1, 3, 1, 1));
    tv.push_back(v(1, 4'b0011, 1, 0, 1, 0, 3, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 0, 1, 0));
    tv.push_back(v(1, 4'b1100, 1, 1, 0, 1, 1, 1, 0));
    tv.push_back(v(1, 4'b1100, 1, 0, 1, 0, 1, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 1, 0, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 2, 1, 0));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 1, 3, 1, 1));
    tv.push_back(v(0, 4'b0000, 1, 0, 1, 0, 3, 1, 0));

    foreach (tv[i]) begin
      @(negedge clk);
      drive0(tv[i].iv, tv[i].d, tv[i].rdy, tv[i].fl);
      #1;
      chk($sformatf("vec%0d.ir", i), int'(b0.in_ready), int'(tv[i].ir));
      chk($sformatf("vec%0d.ov", i), int'(b0.out_valid), int'(tv[i].ov));
      chk($sformatf("vec%0d.busy", i), int'(busy0), int'(tv[i].ov));
      chk($sformatf("vec%0d.sel", i), int'(b0.mux_sel), int'(tv[i].sel));
      chk($sformatf("vec%0d.bit", i), int'(b0.mux_in[b0.mux_sel]),
          int'(tv[i].mbit));
      chk($sformatf("vec%0d.last", i), int'(b0.out_last), int'(tv[i].last));
    end
    @(negedge clk);
    drive0(1'b0, 4'h0, 1'b1, 1'b0);

    // MSB-first word 1000
    drive1(1'b1, 4'b1000, 1'b1, 1'b0);
    #1;
    chk("msb.ir", int'(b1.in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive1(1'b0, 4'h0, 1'b1, 1'b0);
      #1;
      chk($sformatf("msb%0d.ov", k), int'(b1.out_valid), 1);
      chk($sformatf("msb%0d.sel", k), int'(b1.mux_sel), 3 - k);
      chk($sformatf("msb%0d.bit", k), int'(b1.mux_in[b1.mux_sel]),
          (k == 0) ? 1 : 0);
      chk($sformatf("msb%0d.last", k), int'(b1.out_last), (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    chk("msb.idle.ov", int'(b1.out_valid), 0);
    chk("msb.idle.ir", int'(b1.in_ready), 1);

    // asynchronous reset mid-word at sel=10
    @(negedge clk);
    drive0(1'b1, 4'b0101, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive0(1'b0, 4'h0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("arst.pre.sel", int'(b0.mux_sel), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.ov", int'(b0.out_valid), 0);
    chk("arst.busy", int'(busy0), 0);
    chk("arst.sel", int'(b0.mux_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst.ir", int'(b0.in_ready), 1);
    drive0(1'b1, 4'b0101, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive0(1'b0, 4'h0, 1'b1, 1'b0);
      #1;
      chk($sformatf("arst%0d.sel", k), int'(b0.mux_sel), k);
      chk($sformatf("arst%0d.bit", k), int'(b0.mux_in[b0.mux_sel]),
          (k % 2 == 0) ? 1 : 0);
    end

    // randomized run against a queue-of-indices model
    @(negedge clk);
    drive0(1'b0, 4'h0, 1'b0, 1'b0);
    drive1(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      mword[d] = 4'h0;
      held[d] = 2'd0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        r_iv[d]  = ($urandom_range(0, 3) != 0);
        r_d[d]   = 4'($urandom);
        r_rdy[d] = ($urandom_range(0, 3) != 0);
        r_fl[d]  = ($urandom_range(0, 19) == 0);
      end
      drive0(r_iv[0], r_d[0], r_rdy[0], r_fl[0]);
      drive1(r_iv[1], r_d[1], r_rdy[1], r_fl[1]);
      #1;
      a_ir[0] = b0.in_ready; a_ov[0] = b0.out_valid; a_bz[0] = busy0;
      a_sel[0] = b0.mux_sel; a_mi[0] = b0.mux_in; a_last[0] = b0.out_last;
      a_ir[1] = b1.in_ready; a_ov[1] = b1.out_valid; a_bz[1] = busy1;
      a_sel[1] = b1.mux_sel; a_mi[1] = b1.mux_in; a_last[1] = b1.out_last;
      for (int d = 0; d < 2; d++) begin
        e_ov   = (q[d].size() != 0);
        e_sel  = e_ov ? 2'(q[d][0]) : held[d];
        e_last = (q[d].size() == 1);
        e_ir   = !r_fl[d] &&
                 ((q[d].size() == 0) || (q[d].size() == 1 && r_rdy[d]));
        chk($sformatf("rnd%0d.ir", d), int'(a_ir[d]), int'(e_ir));
        chk($sformatf("rnd%0d.ov", d), int'(a_ov[d]), int'(e_ov));
        chk($sformatf("rnd%0d.busy", d), int'(a_bz[d]), int'(e_ov));
        chk($sformatf("rnd%0d.sel", d), int'(a_sel[d]), int'(e_sel));
        chk($sformatf("rnd%0d.min", d), int'(a_mi[d]), int'(mword[d]));
        chk($sformatf("rnd%0d.last", d), int'(a_last[d]), int'(e_last));
        held[d] = e_sel;
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        e_ir = !r_fl[d] &&
               ((q[d].size() == 0) || (q[d].size() == 1 && r_rdy[d]));
        if (r_fl[d]) begin
          q[d].delete();
        end else begin
          if (q[d].size() != 0 && r_rdy[d]) void'(q[d].pop_front());
          if (r_iv[d] && e_ir) begin
            mword[d] = r_d[d];
            q[d].delete();
            for (int k = 0; k < 4; k++) q[d].push_back((d == 1) ? 3 - k : k);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream driver for the parameterized `mux` select block. It accepts a parallel word of 2^N bits over a valid/ready handshake and holds that word on the mux data inputs. It then steps the mux select through every index, one per accepted beat, so the downstream mux output becomes a serial bitstream. A valid/ready/last handshake on the serial side tells the consumer when each mux output bit is valid.

Parameters:
N, 2, select width; the word width is W = 2**N (local, derived, not overridable)
MSB_FIRST, 0, 0: select runs 0 up to W-1; 1: select runs W-1 down to 0

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort: drops the current word, returns to IDLE
in_data  input  W  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept in_data this cycle
mux_in  output  W  registered copy of the accepted word; drives mux `in`
mux_sel  output  N  registered select; drives mux `sel`
out_valid  output  1  the current mux_sel/mux_in pair is a valid serial beat
out_ready  input  1  consumer takes the current beat
out_last  output  1  current beat is the final index of the word
busy  output  1  high while in SHIFT

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, mux_in = 0, mux_sel = 0, out_valid = 0, busy = 0.
  - Reset takes effect immediately, including mid-word; the partial word is discarded and no beat is emitted.
- Constants: FIRST = 0 and LASTI = W-1 when MSB_FIRST = 0; FIRST = W-1 and LASTI = 0 when MSB_FIRST = 1.
- State IDLE:
  - out_valid = 0, busy = 0, in_ready = 1.
  - On in_valid: mux_in <= in_data, mux_sel <= FIRST, go to SHIFT.
  - The first beat is valid on the cycle after acceptance (1-cycle latency).
- State SHIFT:
  - out_valid = 1, busy = 1.
  - out_last = (mux_sel == LASTI). out_last is combinational from mux_sel and is 0 in IDLE.
  - Beat transfer occurs when out_valid & out_ready.
  - Transfer and not out_last: mux_sel <= mux_sel + 1, or - 1 when MSB_FIRST = 1.
  - Transfer and out_last:
    - If in_valid, this is a back-to-back load: mux_in <= in_data, mux_sel <= FIRST, stay in SHIFT. There is no idle bubble between words.
    - Otherwise go to IDLE; mux_sel and mux_in hold their last values.
  - out_ready low: mux_sel, mux_in and out_valid hold (stall for any number of cycles).
- in_ready = (state == IDLE) | (out_valid & out_ready & out_last), with flush low in both cases. Word acceptance = in_valid & in_ready.
- flush (synchronous):
  - Has priority over every other event in the same cycle.
  - Forces state = IDLE and out_valid = 0 on the next edge.
  - in_ready is 0 during a flush cycle, so no word is accepted.
  - mux_in and mux_sel are left unchanged.
- Arithmetic: mux_sel is an N-bit counter. It never wraps within a word, because the out_last transfer always reloads FIRST or exits to IDLE.
- in_data is sampled only on acceptance; changes to in_data at any other time have no effect.
- Degenerate N = 1 (W = 2): two beats per word, and the same rules apply.

Test Plan:
- N=2, MSB_FIRST=0, out_ready=1, load in_data=4'b1010 → the following 4 cycles show mux_sel=00,01,10,11, mux out=0,1,0,1, and out_last only on sel=11. The block is back in IDLE on the 5th cycle with in_ready=1.
- Same word with out_ready low for 3 cycles at sel=01 → mux_sel holds 01 and out_valid stays 1; the sequence resumes 10,11 with no beat lost or duplicated.
- Back-to-back: in_valid held with 4'b1010 then 4'b0110 → 8 consecutive valid beats with mux out 0,1,0,1,0,1,1,0; in_ready pulses high only on the out_last transfer.
- MSB_FIRST=1, in_data=4'b1000 → mux_sel=11,10,01,00, mux out=1,0,0,0; out_last at sel=00.
- rst_n pulled low asynchronously mid-word at sel=10 (between edges) → out_valid, busy and mux_sel go to 0 immediately. After release, in_ready=1 and a fresh word 4'b0101 serializes from sel=00.
- flush at sel=01 with in_valid also high → next cycle IDLE, out_valid=0, the pending word is not accepted. It is accepted on the following cycle.
